// File: rtl/pcnt_pkg.sv
// Shared encodings for the parametrised up/down counter and its one-shot controller.
// Pure declarations: no latency, no flow control.
package pcnt_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } os_state_e;

endpackage

// File: rtl/pcnt_if.sv
// Control/data bundle of one counter stage: loads, direction, mode and compare in; count and flags out.
// Wires only; the counter itself has no handshake and never stalls.
interface pcnt_if #(
  parameter int WIDTH = 8
);
  import pcnt_pkg::*;

  logic             load;
  logic             en;
  logic             ci;
  logic             up;
  mode_e            mode;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] cmp;
  logic [WIDTH-1:0] q;
  logic             co;
  logic             match;
  logic             done;

  modport master (
    output load, en, ci, up, mode, d, cmp,
    input  q, co, match, done
  );

  modport slave (
    input  load, en, ci, up, mode, d, cmp,
    output q, co, match, done
  );

endinterface

// File: rtl/pcnt_fsm.sv
// One-shot controller: IDLE until loaded, RUN while counting, DONE after a step taken at terminal count.
// State and done update on the clock edge (1 cycle); no backpressure, mode change forces IDLE.
module pcnt_fsm
  import pcnt_pkg::*;
(
  input  logic  clk,
  input  logic  mr,
  input  mode_e mode,
  input  logic  load,
  input  logic  step,
  input  logic  at_tc,
  output logic  run,
  output logic  done
);

  os_state_e state, state_nxt;

  always_ff @(posedge clk or negedge mr) begin
    if (!mr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Load outranks the DONE transition so a reload on the terminal step keeps RUN.
  always_comb begin
    state_nxt = state;
    if (mode != MODE_ONESHOT) begin
      state_nxt = IDLE;
    end else if (!load) begin
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     if (step && at_tc) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign run  = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: rtl/pcnt_updown.sv
// Parametrised up/down counter with wrap/saturate/one-shot/hold modes, compare match and cascade carry.
// Load and count take effect on the next edge (1 cycle); co/match are combinational; never stalls.
module pcnt_updown
  import pcnt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MOD   = 2**WIDTH
) (
  input  logic clk,
  input  logic mr,
  pcnt_if.slave bus
);

  localparam logic [WIDTH-1:0] QMAX   = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   QMAX_X = (WIDTH+1)'(MOD - 1);

  logic [WIDTH-1:0] q_r, q_nxt, tc, q_step, wrap_val, d_clamped;
  logic             at_tc, step, run, done;

  assign tc        = bus.up ? QMAX : '0;
  assign at_tc     = (q_r == tc);
  assign step      = bus.en & bus.ci;
  assign q_step    = bus.up ? (q_r + WIDTH'(1)) : (q_r - WIDTH'(1));
  // Explicit wrap target so a non-power-of-two modulus never relies on overflow.
  assign wrap_val  = bus.up ? '0 : QMAX;
  assign d_clamped = ({1'b0, bus.d} > QMAX_X) ? QMAX : bus.d;

  always_comb begin
    q_nxt = q_r;
    if (!bus.load) begin
      q_nxt = d_clamped;
    end else if (step) begin
      case (bus.mode)
        MODE_WRAP:    q_nxt = at_tc ? wrap_val : q_step;
        MODE_SAT:     q_nxt = at_tc ? q_r : q_step;
        MODE_ONESHOT: if (run && !at_tc) q_nxt = q_step;
        MODE_HOLD:    q_nxt = q_r;
        default:      q_nxt = q_r;
      endcase
    end
  end

  always_ff @(posedge clk or negedge mr) begin
    if (!mr) q_r <= '0;
    else     q_r <= q_nxt;
  end

  pcnt_fsm u_fsm (
    .clk   (clk),
    .mr    (mr),
    .mode  (bus.mode),
    .load  (bus.load),
    .step  (step),
    .at_tc (at_tc),
    .run   (run),
    .done  (done)
  );

  assign bus.q     = q_r;
  assign bus.match = (q_r == bus.cmp);
  assign bus.done  = done;
  assign bus.co    = step & at_tc & (bus.mode != MODE_HOLD)
                   & !((bus.mode == MODE_ONESHOT) && !run);

endmodule
